// File: rtl/y86_decode_queue.sv
// Purpose : Y86 byte-aligned instruction buffer and decoder. Assembles 1/2/5/6-byte
//           instructions out of fixed-width fetch words and emits one decoded
//           instruction per cycle.
// Latency : word accepted at edge N -> earliest out_valid after edge N+1.
// Backpr. : in_ready depends only on the registered fill count. Outputs hold
//           while out_valid && !out_ready.
//
// Ports
//   clk, rst               clock; asynchronous active-low reset
//   in_valid/in_ready      fetch word handshake; in_data byte 0 is in bits [7:0]
//   flush, flush_pc        redirect: drop all buffered bytes and restart at flush_pc
//   out_valid/out_ready    decoded instruction handshake
//   icode_o..rB_o          decoded fields as zero-extended nibbles (absent regs = F)
//   valC_o                 little-endian immediate or destination (0 if absent)
//   valP_o, pc_o           next sequential PC and PC of this instruction
//   instr_valid_o          0 for an illegal instruction
//
// Build option: define ID_ILLEGAL_CHECK_EN to enable illegal-instruction
// detection and the ERR state. When it is undefined, every encoding is accepted.

module y86_decode_queue #(
   parameter int FETCH_BYTES = 4,
   parameter int BUF_BYTES   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [8*FETCH_BYTES-1:0] in_data,
   input  logic                     flush,
   input  logic [31:0]              flush_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               icode_o,
   output logic [7:0]               ifun_o,
   output logic [7:0]               rA_o,
   output logic [7:0]               rB_o,
   output logic [31:0]              valC_o,
   output logic [31:0]              valP_o,
   output logic [31:0]              pc_o,
   output logic                     instr_valid_o
);

   localparam int PTR_W = $clog2(BUF_BYTES);
   localparam int CNT_W = PTR_W + 1;

`ifdef ID_ILLEGAL_CHECK_EN
   typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_ERR} state_t;
`else
   typedef enum logic [1:0] {ST_RUN, ST_HALT} state_t;
`endif

   state_t           state, state_nxt;

   logic [7:0]       mem [BUF_BYTES];
   logic [PTR_W-1:0] wptr, rptr;
   logic [CNT_W-1:0] count, count_nxt;
   logic [31:0]      pc;

   logic [7:0]       hb [6];        // the six bytes starting at the read pointer
   logic [3:0]       d_icode, d_ifun, d_ra, d_rb;
   logic [31:0]      d_valc;
   logic [2:0]       d_len;
   logic             d_legal;
   logic             complete;
   logic             push, load;

   // ------------------------------------------------------------------
   // Byte buffer
   // ------------------------------------------------------------------
   // The data array needs no reset. Pointers and count define which
   // bytes are meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         for (int i = 0; i < FETCH_BYTES; i++) begin
            mem[wptr + PTR_W'(i)] <= in_data[8*i +: 8];
         end
      end
   end

   // Bytes past the fill count may be stale. They are only consumed
   // once the count covers the instruction length.
   always_comb begin
      for (int i = 0; i < 6; i++) begin
         hb[i] = mem[rptr + PTR_W'(i)];
      end
   end

   // Space check uses the registered count only. A same-cycle pop is
   // deliberately not credited, so in_ready has no path from out_ready.
   assign in_ready = (CNT_W'(BUF_BYTES) - count) >= CNT_W'(FETCH_BYTES);
   assign push     = in_valid && in_ready && !flush;

   // ------------------------------------------------------------------
   // Head decode
   // ------------------------------------------------------------------
   always_comb begin
      d_icode = hb[0][7:4];
      d_ifun  = hb[0][3:0];
      d_ra    = 4'hF;
      d_rb    = 4'hF;
      d_valc  = 32'h0;
      d_len   = 3'd1;
      d_legal = 1'b1;
      case (d_icode)
         4'h0, 4'h1, 4'h9: d_len = 3'd1;
         4'h2, 4'h6, 4'hA, 4'hB: begin
            d_len = 3'd2;
            d_ra  = hb[1][7:4];
            d_rb  = hb[1][3:0];
         end
         4'h7, 4'h8: begin
            d_len  = 3'd5;
            d_valc = {hb[4], hb[3], hb[2], hb[1]};
         end
         4'h3, 4'h4, 4'h5: begin
            d_len  = 3'd6;
            d_ra   = hb[1][7:4];
            d_rb   = hb[1][3:0];
            d_valc = {hb[5], hb[4], hb[3], hb[2]};
         end
         default: d_len = 3'd1;   // unknown icode: consume one byte only
      endcase
`ifdef ID_ILLEGAL_CHECK_EN
      case (d_icode)
         4'h2, 4'h7: d_legal = (d_ifun <= 4'h6);
         4'h6:       d_legal = (d_ifun <= 4'h3);
         4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB:
                     d_legal = (d_ifun == 4'h0);
         default:    d_legal = 1'b0;
      endcase
      // An illegal byte must not pull operand bytes into the bad
      // instruction. It is emitted alone with empty fields.
      if (!d_legal) begin
         d_len  = 3'd1;
         d_ra   = 4'hF;
         d_rb   = 4'hF;
         d_valc = 32'h0;
      end
`endif
   end

   // When count is at least 1, byte 0 is valid and d_len is meaningful.
   // count >= d_len also covers the empty case, because d_len >= 1.
   assign complete = count >= CNT_W'(d_len);

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_RUN;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      if (flush) begin
         state_nxt = ST_RUN;
      end else begin
         case (state)
            ST_RUN: begin
               if (complete && (!out_valid || out_ready)) begin
                  load = 1'b1;
                  if (d_icode == 4'h0 && d_legal) state_nxt = ST_HALT;
`ifdef ID_ILLEGAL_CHECK_EN
                  else if (!d_legal)              state_nxt = ST_ERR;
`endif
               end
            end
            default: ;   // HALT and ERR leave only on flush or reset
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Pointers, count and PC
   // ------------------------------------------------------------------
   always_comb begin
      count_nxt = count;
      if (push) count_nxt = count_nxt + CNT_W'(FETCH_BYTES);
      if (load) count_nxt = count_nxt - CNT_W'(d_len);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         pc    <= 32'h0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         pc    <= flush_pc;
      end else begin
         count <= count_nxt;
         if (push) wptr <= wptr + PTR_W'(FETCH_BYTES);
         if (load) begin
            rptr <= rptr + PTR_W'(d_len);
            pc   <= pc + 32'(d_len);
         end
      end
   end

   // ------------------------------------------------------------------
   // Output register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid     <= 1'b0;
         icode_o       <= 8'h00;
         ifun_o        <= 8'h00;
         rA_o          <= 8'h0F;
         rB_o          <= 8'h0F;
         valC_o        <= 32'h0;
         valP_o        <= 32'h0;
         pc_o          <= 32'h0;
         instr_valid_o <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid     <= 1'b1;
         icode_o       <= {4'h0, d_icode};
         ifun_o        <= {4'h0, d_ifun};
         rA_o          <= {4'h0, d_ra};
         rB_o          <= {4'h0, d_rb};
         valC_o        <= d_valc;
         valP_o        <= pc + 32'(d_len);
         pc_o          <= pc;
         instr_valid_o <= d_legal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
